// File: rtl/mem_word_fetch.sv
// mem_word_fetch
//
// Streams a burst of consecutive words from a read-only memory into a small
// skid FIFO and presents them on a valid/ready output.
//
// The memory has a registered address and a registered output. A read issued
// with mem_addr=A in cycle t is captured from mem_dataout in cycle t+2. There
// is no enable and no stall, so the block must never issue more reads than the
// FIFO can absorb. Before each issue it checks that the words already in the
// FIFO plus the reads still in flight leave room for one more.
//
// Ports
//   clk          clock; all state updates on its rising edge
//   reset        synchronous, active-high reset
//   start        request a burst; sampled only in IDLE
//   base_addr    first word address; latched on an accepted start
//   count        number of words (0 .. 2^ADDR_WIDTH); latched on an accepted start
//   mem_addr     address to the memory's registered address input
//   mem_dataout  the memory's registered output
//   out_data     head-of-FIFO word (0 when the FIFO is empty)
//   out_valid    out_data holds a valid word
//   out_ready    consumer accepts a word
//   busy         burst in progress (RUN or DRAIN)
//   done         single-cycle burst-complete pulse

module mem_word_fetch #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0]      mem_dataout,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    // Wide enough for fifo_count + inflight (at most 4 + 2).
    localparam int CNT_W = 3;
    localparam int CW    = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]         count_q;
    logic [CW-1:0]         issued_q;
    logic [ADDR_WIDTH-1:0] next_addr_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;

    // Bit 0: a read was issued last cycle; bit 1: a read issued two cycles ago
    // whose data is on mem_dataout now.
    logic [1:0] issue_sr_q;

    logic [WIDTH-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] fifo_count_q;

    logic [CNT_W-1:0] inflight;
    logic             credit_ok;
    logic             accept;
    logic             issue;
    logic             last_issue;
    logic             fifo_push;
    logic             fifo_pop;
    logic             has_word;

    // ------------------------------------------------------------------
    // Issue control
    // ------------------------------------------------------------------
    always_comb begin
        inflight = CNT_W'(issue_sr_q[0]) + CNT_W'(issue_sr_q[1]);
        // A pop in this cycle is deliberately not credited; the slot it frees
        // becomes usable one cycle later.
        credit_ok  = (fifo_count_q + inflight) < CNT_W'(DEPTH);
        accept     = (state_q == StIdle) && start;
        issue      = (state_q == StRun) && (issued_q < count_q) && credit_ok;
        last_issue = issue && ((issued_q + CW'(1)) == count_q);
    end

    // ------------------------------------------------------------------
    // FIFO handshake
    // ------------------------------------------------------------------
    always_comb begin
        has_word  = (fifo_count_q != '0);
        fifo_push = issue_sr_q[1];
        fifo_pop  = has_word && out_ready && !reset;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (count == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (last_issue) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // The last word is the last to arrive, so once nothing is in
                // flight the burst ends as the FIFO's final word is taken.
                if (inflight == '0 &&
                    (fifo_count_q == '0 || (fifo_count_q == CNT_W'(1) && fifo_pop))) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            count_q      <= '0;
            issued_q     <= '0;
            next_addr_q  <= '0;
            last_addr_q  <= '0;
            issue_sr_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                count_q     <= count;
                next_addr_q <= base_addr;
                issued_q    <= '0;
            end

            if (issue) begin
                // Wraps naturally modulo 2^ADDR_WIDTH.
                next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
                last_addr_q <= next_addr_q;
                issued_q    <= issued_q + CW'(1);
            end

            issue_sr_q <= {issue_sr_q[0], issue};

            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end

            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (fifo_push && !reset) begin
            fifo_mem[wr_ptr_q] <= mem_dataout;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (forced to their reset values while reset is asserted)
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr  = '0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        if (!reset) begin
            // Hold the last issued address when not issuing.
            mem_addr  = issue ? next_addr_q : last_addr_q;
            out_valid = has_word;
            out_data  = has_word ? fifo_mem[rd_ptr_q] : '0;
            busy      = (state_q == StRun) || (state_q == StDrain);
            done      = (state_q == StDone);
        end
    end

    // The credit check must make overflow impossible.
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && !fifo_pop && fifo_count_q == CNT_W'(DEPTH)));

endmodule

// File: doc/mem_word_fetch.md
MEM_WORD_FETCH -- requirements
Module: mem_word_fetch

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 7: memory address width in bits.
REQ-003 Parameter DEPTH, fixed at 4: entries in the output skid FIFO.
REQ-004 The block SHALL have one clock and a synchronous active-high reset, with these ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request a burst; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first word address; latched on an accepted start
- count  in  ADDR_WIDTH+1  number of words; latched on an accepted start; 0 is legal
- mem_addr  out  ADDR_WIDTH  address to the read-only memory's registered address input
- mem_dataout  in  WIDTH  the memory's registered output
- out_data  out  WIDTH  head-of-FIFO word
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts a word
- busy  out  1  burst in progress
- done  out  1  single-cycle burst-complete pulse

Function
REQ-005 Memory timing: a read issued with mem_addr=A during cycle t SHALL be captured from mem_dataout in cycle t+2. Fixed 2-cycle latency; the memory has no enable and no stall.
REQ-006 The FSM SHALL have four states: IDLE, RUN, DRAIN, DONE.
REQ-007 IDLE + start=1: latch base_addr and count. If count=0, go to DONE; otherwise go to RUN.
REQ-008 start SHALL be ignored in every state other than IDLE.
REQ-009 RUN: issue one read per cycle when issued<count and (fifo_count + inflight) < DEPTH. Each issued address SHALL be the previous address + 1, modulo 2^ADDR_WIDTH.
REQ-010 Credit check: a pop in the same cycle SHALL NOT count toward the check (conservative credit).
REQ-011 RUN -> DRAIN in the cycle after the last read is issued.
REQ-012 DRAIN -> DONE when inflight=0 and the last word completes out_valid&&out_ready.
REQ-013 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-014 When no read is issued, mem_addr SHALL hold its last value.
REQ-015 A 2-bit per-cycle issue shift register SHALL track in-flight reads. Each returning word SHALL be written to the FIFO in the cycle its read matures.
REQ-016 The FIFO SHALL never overflow; the credit rule guarantees this. Overflow is an assertion failure.
REQ-017 Output handshake:
- out_valid=1 iff fifo_count>0.
- A word is consumed on out_valid&&out_ready.
- out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-018 FIFO write and read in the same cycle: both SHALL occur and fifo_count SHALL be unchanged.
REQ-019 Words SHALL be delivered in issue order, with no loss or duplication.
REQ-020 With out_ready held at 1, throughput SHALL be 1 word per cycle.
REQ-021 Latency: with start accepted in cycle 0, the first mem_addr is driven in cycle 1 and the first out_valid appears in cycle 4.
REQ-022 busy SHALL be 1 in RUN and DRAIN, and 0 in IDLE and DONE.
REQ-023 done SHALL be 1 only in DONE.
REQ-024 count = 2^ADDR_WIDTH (128) SHALL read every address exactly once, wrapping from 127 to 0.

Reset
REQ-025 On reset=1, state SHALL become IDLE and the FIFO and in-flight tracking SHALL be cleared.
REQ-026 Output values during and after reset:
- mem_addr=0, out_valid=0, out_data=0, busy=0, done=0.
- Returning in-flight words SHALL be discarded.
REQ-027 Reset SHALL take priority over start and any handshake in the same cycle.
REQ-028 Reset mid-burst SHALL abort the burst with no done pulse. A start in the cycle after reset deasserts SHALL be accepted.

Verification
Bench model: 2-cycle-latency memory with word(a) = 0x1000 + a.
REQ-029 Basic burst: start, base=5, count=4, out_ready=1 -> out_data 0x1005..0x1008 in cycles 4-7; done=1 in cycle 8; busy=1 in cycles 1-7.
REQ-030 Zero count: start with count=0 -> cycle 1 done=1, busy=0, no out_valid, mem_addr unchanged.
REQ-031 Address wrap: base=126, count=4 -> words 0x107E, 0x107F, 0x1000, 0x1001 in order.
REQ-032 Backpressure: base=0, count=10, out_ready low in cycles 4-12 -> fifo_count never exceeds 4; out_data holds 0x1000 until out_ready returns; all 10 words are then delivered in order.
REQ-033 Reset mid-operation: base=0, count=20, reset in cycle 6 -> next cycle all outputs at reset values and no done pulse; a new start (base=2, count=1) then yields 0x1002 followed by done.
REQ-034 Start while busy: a start pulse during RUN with base=50 -> ignored; the original burst completes unchanged.
